// File: rtl/kv_ctrl_mc.sv
// Key/value cache command controller: IDLE -> LOOKUP -> EXEC -> RESP per request.
// Define KV_CTRL_EVICT_EN to evict round-robin on an UPSERT miss into a full array.
module kv_ctrl_mc #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [NUM_ENTRIES-1:0] used,
    input  logic                   hit,
    input  logic [NUM_ENTRIES-1:0] hit_idx,
    output logic                   mem_lookup,
    output logic                   mem_sel,
    output logic                   mem_write,
    output logic                   mem_delete,
    output logic [NUM_ENTRIES-1:0] mem_idx,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_status,
    output logic [NUM_ENTRIES-1:0] rsp_idx,
    output logic                   timeout_err
);

    localparam int unsigned TW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RSP_TIMEOUT - 1);
    localparam logic [NUM_ENTRIES-1:0] ONE = NUM_ENTRIES'(1);

    typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_e;
    typedef enum logic [1:0] {OP_NOP, OP_GET, OP_UPSERT, OP_DELETE} op_e;
    typedef enum logic [1:0] {ST_OK, ST_MISS, ST_FULL, ST_ERR} status_e;

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic                    hit_q, hit_d;
    logic [NUM_ENTRIES-1:0]  hit_idx_q, hit_idx_d;
    logic [NUM_ENTRIES-1:0]  used_q, used_d;
    status_e                 status_q, status_d;
    logic [NUM_ENTRIES-1:0]  rsp_idx_q, rsp_idx_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    terr_q, terr_d;

    logic [NUM_ENTRIES-1:0]  free_oh;
    logic                    array_full;
    logic                    multi_hit;

    // Lowest clear bit of used, isolated as a one-hot vector.
    assign free_oh    = ~used_q & (used_q + ONE);
    assign array_full = &used_q;
    assign multi_hit  = |(hit_idx_q & (hit_idx_q - ONE));

`ifdef KV_CTRL_EVICT_EN
    localparam int unsigned VW = $clog2(NUM_ENTRIES);
    localparam logic [VW-1:0] VICTIM_LAST = VW'(NUM_ENTRIES - 1);
    logic [VW-1:0] victim_q, victim_d;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        used_d     = used_q;
        status_d   = status_q;
        rsp_idx_d  = rsp_idx_q;
        tmo_d      = tmo_q;
        terr_d     = terr_q;
`ifdef KV_CTRL_EVICT_EN
        victim_d   = victim_q;
`endif
        req_ready  = 1'b0;
        mem_lookup = 1'b0;
        mem_sel    = 1'b0;
        mem_write  = 1'b0;
        mem_delete = 1'b0;
        mem_idx    = '0;
        rsp_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d = op_e'(req_op);
                    if (op_e'(req_op) == OP_NOP) begin
                        state_d   = RESP;
                        status_d  = ST_ERR;
                        rsp_idx_d = '0;
                        tmo_d     = '0;
                    end else begin
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                mem_lookup = 1'b1;
                hit_d      = hit;
                hit_idx_d  = hit_idx;
                used_d     = used;
                state_d    = EXEC;
            end
            EXEC: begin
                state_d  = RESP;
                tmo_d    = '0;
                status_d = ST_MISS;
                if (hit_q && multi_hit) begin
                    status_d = ST_ERR;
                end else begin
                    case (op_q)
                        OP_GET: if (hit_q) begin
                            mem_sel  = 1'b1;
                            mem_idx  = hit_idx_q;
                            status_d = ST_OK;
                        end
                        OP_UPSERT: begin
                            if (hit_q) begin
                                mem_write = 1'b1;
                                mem_idx   = hit_idx_q;
                                status_d  = ST_OK;
                            end else if (!array_full) begin
                                mem_write = 1'b1;
                                mem_idx   = free_oh;
                                status_d  = ST_OK;
                            end else begin
`ifdef KV_CTRL_EVICT_EN
                                mem_write = 1'b1;
                                mem_idx   = ONE << victim_q;
                                status_d  = ST_OK;
                                victim_d  = (victim_q == VICTIM_LAST) ? '0 : victim_q + VW'(1);
`else
                                status_d  = ST_FULL;
`endif
                            end
                        end
                        OP_DELETE: if (hit_q) begin
                            mem_delete = 1'b1;
                            mem_idx    = hit_idx_q;
                            status_d   = ST_OK;
                        end
                        default: status_d = ST_ERR;
                    endcase
                end
                rsp_idx_d = mem_idx;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_status  = rsp_valid ? status_q : ST_OK;
    assign rsp_idx     = rsp_valid ? rsp_idx_q : '0;
    assign timeout_err = terr_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_NOP;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            used_q    <= '0;
            status_q  <= ST_OK;
            rsp_idx_q <= '0;
            tmo_q     <= '0;
            terr_q    <= 1'b0;
`ifdef KV_CTRL_EVICT_EN
            victim_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            used_q    <= used_d;
            status_q  <= status_d;
            rsp_idx_q <= rsp_idx_d;
            tmo_q     <= tmo_d;
            terr_q    <= terr_d;
`ifdef KV_CTRL_EVICT_EN
            victim_q  <= victim_d;
`endif
        end
    end

endmodule

// File: tb/tb_kv_ctrl_mc.sv
// Directed bench for kv_ctrl_mc (16 entries, response timeout of 4 cycles).
module tb_kv_ctrl_mc;

    localparam logic [1:0] NOP = 2'b00, GET = 2'b01, UPS = 2'b10, DEL = 2'b11;
    localparam logic [1:0] OK = 2'b00, MISS = 2'b01, FULL = 2'b10, ERR = 2'b11;
    // Strobe code is {mem_sel, mem_write, mem_delete}.
    localparam logic [2:0] S_NONE = 3'b000, S_SEL = 3'b100, S_WR = 3'b010, S_DEL = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] used;
    logic        hit;
    logic [15:0] hit_idx;
    logic        mem_lookup, mem_sel, mem_write, mem_delete;
    logic [15:0] mem_idx;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_idx;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    kv_ctrl_mc #(.NUM_ENTRIES(16), .RSP_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .used(used), .hit(hit), .hit_idx(hit_idx),
        .mem_lookup(mem_lookup), .mem_sel(mem_sel), .mem_write(mem_write),
        .mem_delete(mem_delete), .mem_idx(mem_idx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_idx(rsp_idx), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle unless hold is set.
    task automatic run_txn(input string name, input logic [1:0] op, input logic h,
                           input logic [15:0] hidx, input logic [15:0] u,
                           input logic [2:0] exp_strb, input logic [15:0] exp_idx,
                           input logic [1:0] exp_st, input bit hold);
        check({name, "/req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = NOP;
        if (op != NOP) begin
            check({name, "/lookup"}, mem_lookup, 1);
            check({name, "/lookup_strb"}, {mem_sel, mem_write, mem_delete}, S_NONE);
            hit = h; hit_idx = hidx; used = u;
            @(negedge clk);
            hit = 1'b0; hit_idx = '0; used = '0;
            check({name, "/strb"}, {mem_sel, mem_write, mem_delete}, exp_strb);
            check({name, "/mem_idx"}, mem_idx, exp_idx);
            check({name, "/exec_rsp_valid"}, rsp_valid, 0);
            @(negedge clk);
        end else begin
            check({name, "/no_lookup"}, mem_lookup, 0);
        end
        check({name, "/rsp_valid"}, rsp_valid, 1);
        check({name, "/rsp_status"}, rsp_status, exp_st);
        check({name, "/rsp_idx"}, rsp_idx, exp_idx);
        if (!hold) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check({name, "/rsp_done"}, rsp_valid, 0);
            check({name, "/idle_ready"}, req_ready, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = NOP; used = '0;
        hit = 1'b0; hit_idx = '0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset/req_ready", req_ready, 1);
        check("reset/outs", {mem_lookup, mem_sel, mem_write, mem_delete, rsp_valid, timeout_err}, 0);
        check("reset/idx", {mem_idx, rsp_idx}, 0);
        check("reset/status", rsp_status, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn("ups_empty", UPS, 1'b0, 16'h0000, 16'h0000, S_WR, 16'h0001, OK, 0);
        run_txn("get_hit", GET, 1'b1, 16'h0020, 16'h0021, S_SEL, 16'h0020, OK, 0);
        run_txn("get_miss", GET, 1'b0, 16'h0000, 16'h0021, S_NONE, 16'h0000, MISS, 0);
        run_txn("del_hit", DEL, 1'b1, 16'h8000, 16'h8000, S_DEL, 16'h8000, OK, 0);
        run_txn("nop", NOP, 1'b0, 16'h0000, 16'h0000, S_NONE, 16'h0000, ERR, 0);
        run_txn("del_miss", DEL, 1'b0, 16'h0000, 16'h00F0, S_NONE, 16'h0000, MISS, 0);
        run_txn("ups_hit", UPS, 1'b1, 16'h0004, 16'hFFFF, S_WR, 16'h0004, OK, 0);
        run_txn("ups_free", UPS, 1'b0, 16'h0000, 16'h00FF, S_WR, 16'h0100, OK, 0);
        run_txn("ups_gap", UPS, 1'b0, 16'h0000, 16'hFFEF, S_WR, 16'h0010, OK, 0);
        run_txn("multi_hit", GET, 1'b1, 16'h0011, 16'h0011, S_NONE, 16'h0000, ERR, 0);

`ifdef KV_CTRL_EVICT_EN
        run_txn("evict0", UPS, 1'b0, 16'h0000, 16'hFFFF, S_WR, 16'h0001, OK, 0);
        run_txn("evict1", UPS, 1'b0, 16'h0000, 16'hFFFF, S_WR, 16'h0002, OK, 0);
        run_txn("evict2", UPS, 1'b0, 16'h0000, 16'hFFFF, S_WR, 16'h0004, OK, 0);
`else
        run_txn("full", UPS, 1'b0, 16'h0000, 16'hFFFF, S_NONE, 16'h0000, FULL, 0);
`endif

        // Response dropped after four unanswered cycles.
        check("tmo/err_before", timeout_err, 0);
        run_txn("tmo", GET, 1'b1, 16'h0020, 16'h0020, S_SEL, 16'h0020, OK, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("tmo/valid_%0d", i + 1), rsp_valid, 1);
        end
        @(negedge clk);
        check("tmo/valid_dropped", rsp_valid, 0);
        check("tmo/err_set", timeout_err, 1);
        check("tmo/req_ready", req_ready, 1);
        run_txn("after_tmo", GET, 1'b0, 16'h0000, 16'h0000, S_NONE, 16'h0000, MISS, 0);
        check("tmo/err_sticky", timeout_err, 1);

        // Reset during EXEC of an UPSERT.
        req_valid = 1'b1; req_op = UPS;
        @(negedge clk);
        req_valid = 1'b0; req_op = NOP;
        hit = 1'b0; used = 16'h0003;
        @(negedge clk);
        used = '0;
        check("rst_exec/write", mem_write, 1);
        check("rst_exec/idx", mem_idx, 16'h0004);
        #1 rst_n = 1'b0;
        #1;
        check("rst_exec/write_drop", mem_write, 0);
        check("rst_exec/idx_drop", mem_idx, 0);
        check("rst_exec/outs", {mem_lookup, mem_sel, mem_delete, rsp_valid, timeout_err}, 0);
        check("rst_exec/req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_exec/no_rsp", rsp_valid, 0);
        check("rst_exec/err_clear", timeout_err, 0);
        run_txn("post_rst_get", GET, 1'b1, 16'h0002, 16'h0002, S_SEL, 16'h0002, OK, 0);
`ifdef KV_CTRL_EVICT_EN
        run_txn("post_rst_evict", UPS, 1'b0, 16'h0000, 16'hFFFF, S_WR, 16'h0001, OK, 0);
`else
        run_txn("post_rst_full", UPS, 1'b0, 16'h0000, 16'hFFFF, S_NONE, 16'h0000, FULL, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kv_ctrl_mc.md
Name: kv_ctrl_mc

Overview:
- Second-generation command controller for the key/value cache memory array.
- Accepts one GET/UPSERT/DELETE request per transaction over a valid/ready handshake and runs a lookup phase, then an execute phase.
- Drives one-hot select/write/delete strobes into the memory array and returns a status code over a valid/ready response handshake.
- Adds over the first generation:
  - parametrised depth;
  - free-slot allocation from the used vector;
  - full-array detection;
  - response timeout;
  - optional round-robin eviction.

Parameters:
NUM_ENTRIES, 16, number of cache entries; width of all one-hot index and used vectors; must be >= 2.
RSP_TIMEOUT, 255, maximum cycles RESP waits for rsp_ready before dropping the response; must be >= 1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request; high only in IDLE.
req_op  input  2  00 NOP, 01 GET, 10 UPSERT, 11 DELETE.
used  input  NUM_ENTRIES  occupancy vector from the memory array.
hit  input  1  key-compare hit from the memory array; valid while mem_lookup is high.
hit_idx  input  NUM_ENTRIES  one-hot matching entry; valid with hit.
mem_lookup  output  1  memory performs key compare this cycle.
mem_sel  output  1  read strobe for entry mem_idx.
mem_write  output  1  write strobe for entry mem_idx.
mem_delete  output  1  clear strobe for entry mem_idx.
mem_idx  output  NUM_ENTRIES  one-hot target entry; all zeros when no strobe is active.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_status  output  2  00 OK, 01 MISS, 10 FULL, 11 ERR.
rsp_idx  output  NUM_ENTRIES  one-hot entry acted upon; all zeros for MISS, FULL and ERR.
timeout_err  output  1  sticky; set when a response is dropped; cleared only by reset.

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; victim pointer 0; timeout counter 0.
- States: IDLE, LOOKUP, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge, register op; go to LOOKUP.
  - NOP: go directly to RESP with status ERR.
- LOOKUP (1 cycle):
  - mem_lookup=1.
  - Register hit, hit_idx and used at the end of the cycle; go to EXEC.
- EXEC (1 cycle): exactly one strobe at most; action by op:
  - GET hit: mem_sel=1, mem_idx=hit_idx, status OK.
  - GET miss: no strobe, status MISS.
  - UPSERT hit: mem_write=1, mem_idx=hit_idx, status OK.
  - UPSERT miss with free entry: mem_write=1, mem_idx = lowest-index zero bit of the registered used vector, status OK.
  - UPSERT miss with all entries used: see Optional Feature.
  - DELETE hit: mem_delete=1, mem_idx=hit_idx, status OK.
  - DELETE miss: no strobe, status MISS.
  - rsp_idx latches mem_idx (zeros when no strobe). Go to RESP.
- RESP:
  - rsp_valid=1; rsp_status and rsp_idx held stable.
  - On rsp_valid && rsp_ready: go to IDLE.
  - Timeout counter increments each waiting cycle. After RSP_TIMEOUT cycles without rsp_ready: drop the response, set timeout_err, go to IDLE.
  - Counter clears on entry to RESP.
- Latency: request accepted at edge N gives mem_lookup in cycle N+1, strobe in cycle N+2, rsp_valid first high in cycle N+3. Back-to-back throughput is one request per 4 cycles minimum.
- A hit_idx with more than one bit set while hit=1 is a memory fault: no strobe, status ERR.
- req_valid outside IDLE is ignored; req_ready=0.
- Reset asserted mid-transaction aborts immediately: strobes drop asynchronously and no response is issued.

Optional Feature:
Macro KV_CTRL_EVICT_EN.
- Defined, UPSERT miss with the array full:
  - Evict the entry at the victim pointer: mem_write=1, mem_idx = one-hot(victim), status OK.
  - Victim pointer then increments, wrapping NUM_ENTRIES-1 to 0.
  - The pointer advances only on an eviction.
- Undefined, same case: no strobe, status FULL, victim pointer logic absent.

Test Plan:
1. Reset, then UPSERT with used=0, hit=0 -> cycle N+2: mem_write=1, mem_idx=0x0001; then rsp_status=OK, rsp_idx=0x0001.
2. GET with hit=1, hit_idx=0x0020 -> mem_sel=1, mem_idx=0x0020; rsp OK; rsp_idx=0x0020. GET with hit=0 -> no strobe, rsp MISS, rsp_idx=0.
3. DELETE with hit=1, hit_idx=0x8000 -> mem_delete=1, mem_idx=0x8000, rsp OK. NOP request -> rsp ERR with no mem_lookup.
4. UPSERT miss with used=0xFFFF:
   - Without the macro -> rsp FULL, no strobe.
   - With the macro, three consecutive such upserts -> mem_idx 0x0001, 0x0002, 0x0004.
5. Hold rsp_ready=0 with RSP_TIMEOUT=4 -> rsp_valid high for 4 cycles, then low; timeout_err=1 and stays 1; req_ready=1 next cycle.
6. Assert rst_n low during EXEC of an UPSERT -> mem_write drops immediately, no rsp_valid, all outputs at reset values.
